// File: rtl/ahb_arbiter.sv
// Four-master AHB bus arbiter: round-robin grant with fixed-length burst hold and locked-transfer
// hold; all outputs registered and advance only on accepted (HREADY=1) transfers.
module ahb_arbiter #(
  parameter int unsigned NUM_MASTERS    = 4,
  parameter int unsigned DEFAULT_MASTER = 0
) (
  input  logic                   HCLK,
  input  logic                   HRESET,
  input  logic [NUM_MASTERS-1:0] HBUSREQ,
  input  logic [NUM_MASTERS-1:0] HLOCK,
  input  logic [1:0]             HTRANS,
  input  logic [2:0]             HBURST,
  input  logic                   HREADY,
  output logic [NUM_MASTERS-1:0] HGRANT,
  output logic [1:0]             HMASTER,
  output logic                   HMASTLOCK
);

  localparam logic [1:0] ST_ARB   = 2'd0;
  localparam logic [1:0] ST_BURST = 2'd1;
  localparam logic [1:0] ST_LOCK  = 2'd2;

  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_BUSY   = 2'b01;
  localparam logic [1:0] TR_NONSEQ = 2'b10;
  localparam logic [1:0] TR_SEQ    = 2'b11;

  localparam logic [1:0]             DEF_IDX   = DEFAULT_MASTER[1:0];
  localparam logic [NUM_MASTERS-1:0] ONE       = {{(NUM_MASTERS-1){1'b0}}, 1'b1};
  localparam logic [NUM_MASTERS-1:0] DEF_GRANT = ONE << DEF_IDX;

  logic [1:0]             r_state;
  logic [3:0]             r_cnt;
  logic [NUM_MASTERS-1:0] r_grant;
  logic [1:0]             r_master;
  logic                   r_mastlock;

  logic [1:0] w_g;
  logic [1:0] w_rr;
  logic       w_found;
  logic [3:0] w_len_m1;
  logic       w_fixed;
  logic [1:0] w_state_nxt;
  logic [3:0] w_cnt_nxt;
  logic [1:0] w_gidx_nxt;

  // Grant is one-hot by construction, so a priority encode recovers its index.
  always_comb begin
    w_g = 2'd0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (r_grant[i]) w_g = i[1:0];
    end
  end

  always_comb begin
    w_rr    = DEF_IDX;
    w_found = 1'b0;
    for (int k = 1; k <= NUM_MASTERS; k++) begin
      if (!w_found && HBUSREQ[w_g + k[1:0]]) begin
        w_rr    = w_g + k[1:0];
        w_found = 1'b1;
      end
    end
  end

  always_comb begin
    case (HBURST)
      3'b010, 3'b011: w_len_m1 = 4'd3;
      3'b100, 3'b101: w_len_m1 = 4'd7;
      3'b110, 3'b111: w_len_m1 = 4'd15;
      default:        w_len_m1 = 4'd0;
    endcase
  end

  assign w_fixed = (HBURST[2:1] != 2'b00);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_gidx_nxt  = w_g;
    case (r_state)
      ST_ARB: begin
        if (HLOCK[w_g] && HBUSREQ[w_g]) begin
          w_state_nxt = ST_LOCK;
        end else if (HTRANS == TR_NONSEQ && w_fixed) begin
          w_state_nxt = ST_BURST;
          w_cnt_nxt   = w_len_m1;
        end else begin
          w_gidx_nxt = w_rr;
        end
      end
      ST_BURST: begin
        case (HTRANS)
          TR_SEQ: begin
            // Counter never goes below 1 here; the beat seen at 1 is the last.
            if (r_cnt <= 4'd1) begin
              w_cnt_nxt = 4'd0;
              if (HLOCK[w_g]) begin
                w_state_nxt = ST_LOCK;
              end else begin
                w_state_nxt = ST_ARB;
                w_gidx_nxt  = w_rr;
              end
            end else begin
              w_cnt_nxt = r_cnt - 4'd1;
            end
          end
          TR_BUSY: ;
          default: begin
            w_cnt_nxt   = 4'd0;
            w_state_nxt = ST_ARB;
            w_gidx_nxt  = w_rr;
          end
        endcase
      end
      ST_LOCK: begin
        if (!HLOCK[w_g] && HTRANS == TR_IDLE) begin
          w_state_nxt = ST_ARB;
          w_gidx_nxt  = w_rr;
        end
      end
      default: begin
        w_state_nxt = ST_ARB;
        w_cnt_nxt   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_state    <= ST_ARB;
      r_cnt      <= 4'd0;
      r_grant    <= DEF_GRANT;
      r_master   <= 2'd0;
      r_mastlock <= 1'b0;
    end else if (HREADY) begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_grant    <= ONE << w_gidx_nxt;
      r_master   <= w_g;
      r_mastlock <= HLOCK[w_g];
    end
  end

  assign HGRANT    = r_grant;
  assign HMASTER   = r_master;
  assign HMASTLOCK = r_mastlock;

endmodule

// File: doc/ahb_arbiter.md
AHB_ARBITER -- requirements
Module: ahb_arbiter

Interface
REQ-001 Parameter NUM_MASTERS, default 4, number of requesting masters; the only supported value is 4.
REQ-002 Parameter DEFAULT_MASTER, default 0, master granted when no request is pending.
REQ-003 HCLK  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 HRESET  input  1  asynchronous, active-high reset.
REQ-005 HBUSREQ  input  4  per-master bus request, bit i = master i.
REQ-006 HLOCK  input  4  per-master locked-transfer request.
REQ-007 HTRANS  input  2  transfer type of the shared bus: IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
REQ-008 HBURST  input  3  burst type of the shared bus, standard AHB encoding.
REQ-009 HREADY  input  1  shared transfer-complete signal.
REQ-010 HGRANT  output  4  one-hot grant, registered.
REQ-011 HMASTER  output  2  index of the master owning the address phase, registered.
REQ-012 HMASTLOCK  output  1  current address phase is locked, registered.

Function
REQ-013 The block SHALL have an FSM with three states: ARB, BURST and LOCK. Let g be the index of the set HGRANT bit.
REQ-014 All updates of HGRANT, HMASTER and HMASTLOCK SHALL occur only on an edge where HREADY=1. When HREADY=0, all outputs and the FSM SHALL hold.
REQ-015 In ARB with HREADY=1, the next grant SHALL be picked round-robin. Search order is g+1, g+2, g+3, g (mod 4) over HBUSREQ. The first set bit wins. If no bit is set, the grant SHALL go to DEFAULT_MASTER.
REQ-016 HGRANT SHALL be exactly one-hot at all times. No cycle SHALL have zero grants or multiple grants.
REQ-017 HMASTER SHALL load g on every HREADY=1 edge, so that it lags HGRANT by one accepted transfer. HMASTLOCK SHALL load HLOCK[g] on the same edge.
REQ-018 Burst length from HBURST: WRAP4/INCR4 = 4, WRAP8/INCR8 = 8, WRAP16/INCR16 = 16. SINGLE and INCR are undefined-length and SHALL NOT enter BURST.
REQ-019 ARB -> BURST: on HREADY=1 with HTRANS=NONSEQ and a fixed-length HBURST. A 4-bit counter SHALL load length-1 and the grant SHALL be held at g.
REQ-020 In BURST:
- HREADY=1 with HTRANS=SEQ SHALL decrement the counter.
- HTRANS=BUSY SHALL hold the counter.
- Grant SHALL stay at g.
REQ-021 BURST -> ARB (or -> LOCK if HLOCK[g]=1): when HREADY=1, HTRANS=SEQ and counter=1, i.e. the final beat is accepted. Round-robin arbitration SHALL be performed on that same edge.
REQ-022 BURST -> ARB early termination: HREADY=1 with HTRANS=IDLE or HTRANS=NONSEQ. The counter SHALL clear, and arbitration SHALL be performed on that edge.
REQ-023 ARB -> LOCK: on HREADY=1 with HLOCK[g]=1 and HBUSREQ[g]=1. The grant SHALL stay at g and the round-robin search SHALL be skipped.
REQ-024 In LOCK the grant SHALL be held unconditionally. LOCK -> ARB when HREADY=1, HLOCK[g]=0 and HTRANS=IDLE; arbitration SHALL be performed on that edge.
REQ-025 Simultaneous events:
- Lock takes priority over a new fixed burst start in ARB; the burst counter is not loaded in LOCK.
- Requests arriving mid-burst SHALL wait.
REQ-026 Requests deasserted by a non-granted master before arbitration SHALL be ignored; no request latching.
REQ-027 Counter arithmetic SHALL be 4-bit unsigned; load values are 3, 7, 15. Decrement below 0 SHALL NOT occur.

Reset
REQ-028 While HRESET=1, asynchronously:
- HGRANT = one-hot(DEFAULT_MASTER) = 4'b0001
- HMASTER = 2'd0
- HMASTLOCK = 0
- state = ARB
- counter = 0
- last-grant pointer = DEFAULT_MASTER
REQ-029 Reset asserted mid-burst or mid-lock SHALL abandon it immediately. The first post-reset arbitration SHALL follow REQ-015 from g=DEFAULT_MASTER.

Verification
REQ-030 The bench SHALL cover the following directed scenarios:
- Rotation: HBUSREQ=4'b1111, HREADY=1, HTRANS=IDLE -> HGRANT sequence 0010, 0100, 1000, 0001, 0010; HMASTER 1, 2, 3, 0 one cycle later.
- Fixed burst: master 2 granted, NONSEQ + INCR4, HBUSREQ=4'b1111 -> grant stays 0100 for 4 accepted beats, then moves to 1000 on the final SEQ edge.
- Wait states: same INCR4 with HREADY=0 for 2 cycles on beat 2 -> counter and grant frozen; handover occurs after beat 4 is accepted.
- Lock: master 1 granted, HLOCK=4'b0010, HBUSREQ=4'b1011 -> grant held at 0010 and HMASTLOCK=1. After HLOCK drops with HTRANS=IDLE, the next grant is 1000.
- Early termination and idle default: WRAP8 ended by HTRANS=IDLE after 3 beats -> ARB. Then with HBUSREQ=0 -> HGRANT=0001.
- Reset mid-burst: HRESET pulse during INCR16 beat 5 -> outputs read 0001 / 0 / 0 in the same cycle, and the FSM is in ARB.
